// File: rtl/cpu_prefetch_unit_pkg.sv
// Shared definitions for the instruction prefetch unit: FSM state encodings
// and small helpers used by the unit and its queue.
package cpu_prefetch_unit_pkg;

    typedef logic [1:0] pf_state_t;

    localparam pf_state_t PF_IDLE = 2'd0;
    localparam pf_state_t PF_REQ  = 2'd1;
    localparam pf_state_t PF_GAP  = 2'd2;
    localparam pf_state_t PF_HELD = 2'd3;

    // A bus read finishes on the first edge where the request is up and the slave is not stalling.
    function automatic logic pf_read_done(input logic read_req, input logic wait_req);
        return read_req & ~wait_req;
    endfunction

endpackage

// File: rtl/cpu_prefetch_fifo.sv
// Circular queue of fetched bytes tagged with their fetch address.
// Head is presented combinationally and reads as zero when the queue is empty.
module cpu_prefetch_fifo
    import cpu_prefetch_unit_pkg::*;
#(
    parameter int WIDTH = 24,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    input  logic                         clear,
    output logic [WIDTH-1:0]             head_data,
    output logic [$clog2(DEPTH):0]       count,
    output logic                         empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             full_s;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full_s    = (count_r == CNT_W'(DEPTH));
    assign empty     = (count_r == CNT_W'(0));
    assign count     = count_r;
    assign pop_ok_s  = pop & ~empty & ~clear;
    assign push_ok_s = push & ~clear & (~full_s | pop_ok_s);
    assign head_data = empty ? WIDTH'(0) : mem_r[rd_ptr_r];

    // Storage array write port; contents need no reset because the head is masked when empty.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; clear wins over any same-edge push or pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= PTR_W'(0);
            rd_ptr_r <= PTR_W'(0);
            count_r  <= CNT_W'(0);
        end else if (clear) begin
            wr_ptr_r <= PTR_W'(0);
            rd_ptr_r <= PTR_W'(0);
            count_r  <= CNT_W'(0);
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/cpu_prefetch_unit.sv
// Instruction-byte prefetcher: issues sequential single-outstanding bus reads,
// buffers fetched bytes with their address, supports redirect and bus hold.
module cpu_prefetch_unit
    import cpu_prefetch_unit_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  active,
    input  logic                  flush,
    input  logic [ADDR_WIDTH-1:0] flush_addr,
    input  logic                  hold_req,
    output logic                  hold_grant,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0] out_pc,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH-1:0] bus_address_out,
    output logic                  bus_read,
    input  logic [DATA_WIDTH-1:0] bus_data_in,
    input  logic                  bus_wait
);

    localparam int CNT_W   = $clog2(DEPTH) + 1;
    localparam int ENTRY_W = DATA_WIDTH + ADDR_WIDTH;

    pf_state_t             state_r;
    pf_state_t             state_nxt_s;
    logic [ADDR_WIDTH-1:0] fetch_pc_r;
    logic [ADDR_WIDTH-1:0] fetch_pc_nxt_s;
    logic [ADDR_WIDTH-1:0] bus_addr_nxt_s;
    logic                  bus_read_nxt_s;
    logic                  hold_grant_nxt_s;
    logic                  drop_r;
    logic                  drop_nxt_s;
    logic                  push_s;
    logic                  pop_s;
    logic                  clear_s;
    logic                  done_s;
    logic                  room_s;
    logic [CNT_W-1:0]      fifo_count_s;
    logic                  fifo_empty_s;
    logic [ENTRY_W-1:0]    head_s;

    assign done_s    = pf_read_done(bus_read, bus_wait);
    assign room_s    = (fifo_count_s < CNT_W'(DEPTH));
    assign clear_s   = active & flush;
    assign pop_s     = active & ~flush & out_valid & out_ready;
    assign out_valid = ~fifo_empty_s;
    assign out_data  = head_s[ENTRY_W-1:ADDR_WIDTH];
    assign out_pc    = head_s[ADDR_WIDTH-1:0];

    cpu_prefetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_s),
        .push_data ({bus_data_in, bus_address_out}),
        .pop       (pop_s),
        .clear     (clear_s),
        .head_data (head_s),
        .count     (fifo_count_s),
        .empty     (fifo_empty_s)
    );

    // Next-state, bus-request and queue-push decisions; nothing moves while inactive.
    always_comb begin
        state_nxt_s      = state_r;
        fetch_pc_nxt_s   = fetch_pc_r;
        bus_addr_nxt_s   = bus_address_out;
        bus_read_nxt_s   = bus_read;
        hold_grant_nxt_s = hold_grant;
        drop_nxt_s       = drop_r;
        push_s           = 1'b0;
        if (active) begin
            if (flush) begin
                fetch_pc_nxt_s = flush_addr;
            end else begin
                fetch_pc_nxt_s = fetch_pc_r;
            end
            case (state_r)
                PF_IDLE: begin
                    if (hold_req) begin
                        state_nxt_s      = PF_HELD;
                        hold_grant_nxt_s = 1'b1;
                    end else if (!flush && room_s) begin
                        bus_addr_nxt_s = fetch_pc_r;
                        bus_read_nxt_s = 1'b1;
                        fetch_pc_nxt_s = fetch_pc_r + ADDR_WIDTH'(1);
                        state_nxt_s    = PF_REQ;
                    end else begin
                        state_nxt_s = PF_IDLE;
                    end
                end
                PF_REQ: begin
                    // A byte completing on the flush edge is simply not queued, so
                    // drop must not linger and eat the first byte of the new stream.
                    if (done_s) begin
                        bus_read_nxt_s = 1'b0;
                        state_nxt_s    = PF_GAP;
                        drop_nxt_s     = 1'b0;
                        push_s         = ~drop_r & ~flush;
                    end else if (flush) begin
                        drop_nxt_s = 1'b1;
                    end else begin
                        drop_nxt_s = drop_r;
                    end
                end
                PF_GAP: begin
                    state_nxt_s = PF_IDLE;
                end
                PF_HELD: begin
                    if (!hold_req) begin
                        hold_grant_nxt_s = 1'b0;
                        state_nxt_s      = PF_IDLE;
                    end else begin
                        hold_grant_nxt_s = 1'b1;
                    end
                end
                default: begin
                    state_nxt_s      = PF_IDLE;
                    bus_read_nxt_s   = 1'b0;
                    hold_grant_nxt_s = 1'b0;
                    drop_nxt_s       = 1'b0;
                end
            endcase
        end else begin
            push_s = 1'b0;
        end
    end

    // Control and bus output registers; reset drops bus_read immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r         <= PF_IDLE;
            fetch_pc_r      <= ADDR_WIDTH'(0);
            bus_address_out <= ADDR_WIDTH'(0);
            bus_read        <= 1'b0;
            hold_grant      <= 1'b0;
            drop_r          <= 1'b0;
        end else begin
            state_r         <= state_nxt_s;
            fetch_pc_r      <= fetch_pc_nxt_s;
            bus_address_out <= bus_addr_nxt_s;
            bus_read        <= bus_read_nxt_s;
            hold_grant      <= hold_grant_nxt_s;
            drop_r          <= drop_nxt_s;
        end
    end

endmodule

// File: tb/tb_cpu_prefetch_unit.sv
// Scoreboard bench for cpu_prefetch_unit: directed scenarios then randomized traffic
// against a sequential-stream reference model.
module tb_cpu_prefetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        active;
    logic        flush;
    logic [15:0] flush_addr;
    logic        hold_req;
    logic        hold_grant;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [15:0] out_pc;
    logic        out_ready;
    logic [15:0] bus_address_out;
    logic        bus_read;
    logic [7:0]  bus_data_in;
    logic        bus_wait = 1'b0;

    int checks = 0;
    int failures = 0;
    int pops = 0;
    logic [15:0] last_pop_pc = 16'h0;
    logic [15:0] exp_q[$];
    logic [15:0] issue_q[$];
    longint      issue_t[$];

    int          stall_left = 0;
    int          stall_applied = 0;
    logic [15:0] stall_addr = 16'h0;
    bit          rand_wait = 1'b0;

    cpu_prefetch_unit #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .active(active), .flush(flush), .flush_addr(flush_addr),
        .hold_req(hold_req), .hold_grant(hold_grant), .out_valid(out_valid),
        .out_data(out_data), .out_pc(out_pc), .out_ready(out_ready),
        .bus_address_out(bus_address_out), .bus_read(bus_read),
        .bus_data_in(bus_data_in), .bus_wait(bus_wait)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mem_byte(input logic [15:0] a);
        if (a[15:4] == 12'h000) return a[7:0];
        return (a[7:0] + 8'h90) ^ a[15:8];
    endfunction

    assign bus_data_in = mem_byte(bus_address_out);

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_flush(input logic [15:0] a);
        flush = 1'b1;
        flush_addr = a;
        exp_q.delete();
        exp_q.push_back(a);
        tick();
        flush = 1'b0;
    endtask

    task automatic wait_pops(input int n, input string name);
        int target;
        int k;
        target = pops + n;
        k = 0;
        while (pops < target && k < 2000) begin tick(); k++; end
        chk(name, 32'(pops >= target), 32'd1);
    endtask

    // Slave model: optional targeted stall on one address, else random or zero wait.
    always @(posedge clk) begin
        #1;
        if (stall_left > 0 && bus_read && bus_address_out == stall_addr) begin
            bus_wait = 1'b1;
            stall_left--;
            stall_applied++;
        end else if (rand_wait) begin
            bus_wait = ($urandom_range(0, 2) == 0);
        end else begin
            bus_wait = 1'b0;
        end
    end

    logic        p_read = 1'b0;
    logic        p_wait = 1'b0;
    logic        p_ok = 1'b0;
    logic [15:0] p_addr = 16'h0;

    // Monitor: scoreboard pops, empty-head values, hold/bus exclusion, stall stability, issue log.
    always @(negedge clk) begin
        logic [15:0] e;
        if (!rst) begin
            if (active && out_valid && out_ready && !flush) begin
                if (exp_q.size() == 0) exp_q.push_back(16'h0);
                e = exp_q.pop_front();
                if (exp_q.size() == 0) exp_q.push_back(e + 16'h1);
                checks++;
                if (out_pc !== e || out_data !== mem_byte(e)) begin
                    failures++;
                    $display("FAIL pop: got pc=%h data=%h expected pc=%h data=%h",
                             out_pc, out_data, e, mem_byte(e));
                end
                pops++;
                last_pop_pc = out_pc;
            end
            if (!out_valid) begin
                checks++;
                if (out_data !== 8'h0 || out_pc !== 16'h0) begin
                    failures++;
                    $display("FAIL empty_head: got data=%h pc=%h expected 00/0000", out_data, out_pc);
                end
            end
            if (hold_grant) begin
                checks++;
                if (bus_read) begin
                    failures++;
                    $display("FAIL hold_excl: got bus_read=1 with hold_grant=1 expected 0");
                end
            end
            if (p_ok && p_read && p_wait) begin
                checks++;
                if (!bus_read || bus_address_out !== p_addr) begin
                    failures++;
                    $display("FAIL stall_stable: got read=%b addr=%h expected 1/%h",
                             bus_read, bus_address_out, p_addr);
                end
            end
            if (bus_read && !p_read) begin
                issue_q.push_back(bus_address_out);
                issue_t.push_back(longint'($time));
            end
        end
        p_ok   = !rst;
        p_read = bus_read;
        p_wait = bus_wait;
        p_addr = bus_address_out;
    end

    initial begin
        int n;
        int k;
        int pops0;
        rst = 1'b1; active = 1'b1; flush = 1'b0; flush_addr = 16'h0;
        hold_req = 1'b0; out_ready = 1'b0;
        exp_q.push_back(16'h0000);

        // Reset state
        @(negedge clk); @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_bus_read", 32'(bus_read), 32'd0);
        chk("rst_bus_addr", 32'(bus_address_out), 32'd0);
        chk("rst_hold_grant", 32'(hold_grant), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_pc", 32'(out_pc), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Fill from reset: reads 0..3 at 3-cycle spacing, then the bus goes quiet
        repeat (30) tick();
        chk("fill_issue_count", 32'(issue_q.size()), 32'd4);
        for (int i = 0; i < 4 && i < issue_q.size(); i++) begin
            chk("fill_issue_addr", 32'(issue_q[i]), 32'(i));
            if (i > 0) chk("fill_spacing", 32'(issue_t[i] - issue_t[i-1]), 32'd30);
        end
        chk("fill_idle_bus", 32'(bus_read), 32'd0);
        chk("fill_head_valid", 32'(out_valid), 32'd1);
        chk("fill_head_data", 32'(out_data), 32'h00);
        chk("fill_head_pc", 32'(out_pc), 32'h0000);

        // Continuous consumption of 50 bytes from 0x0010
        out_ready = 1'b1;
        do_flush(16'h0010);
        wait_pops(50, "stream50_done");

        // Five-cycle stall on the read of 0x0002
        stall_addr = 16'h0002; stall_left = 5; stall_applied = 0;
        do_flush(16'h0000);
        k = 0;
        while (last_pop_pc != 16'h0003 && k < 300) begin tick(); k++; end
        chk("stall_reached", 32'(last_pop_pc), 32'h0003);
        chk("stall_cycles", 32'(stall_applied), 32'd5);

        // Redirect while 0x0005 is in flight with three bytes queued
        out_ready = 1'b0;
        stall_addr = 16'h0005; stall_left = 4;
        do_flush(16'h0002);
        k = 0;
        while (!(bus_read && bus_address_out == 16'h0005) && k < 100) begin tick(); k++; end
        chk("redir_inflight", 32'(bus_read && bus_address_out == 16'h0005), 32'd1);
        chk("redir_queued", 32'(out_valid), 32'd1);
        do_flush(16'h1234);
        chk("redir_emptied", 32'(out_valid), 32'd0);
        n = issue_q.size();
        k = 0;
        while (issue_q.size() <= n && k < 100) begin tick(); k++; end
        chk("redir_next_issue", 32'(issue_q.size() > n ? issue_q[n] : 16'h0), 32'h1234);
        out_ready = 1'b1;
        wait_pops(3, "redir_pops");

        // Address wrap at 0xFFFF
        do_flush(16'hFFFF);
        n = issue_q.size();
        wait_pops(5, "wrap_pops");
        chk("wrap_issue0", 32'(issue_q.size() > n + 1 ? issue_q[n] : 16'h0), 32'hFFFF);
        chk("wrap_issue1", 32'(issue_q.size() > n + 1 ? issue_q[n+1] : 16'h1), 32'h0000);

        // Hold requested while a read is outstanding
        stall_addr = 16'h0041; stall_left = 3;
        do_flush(16'h0040);
        k = 0;
        while (!(bus_read && bus_address_out == 16'h0041) && k < 100) begin tick(); k++; end
        hold_req = 1'b1;
        k = 0;
        while (!hold_grant && k < 50) begin tick(); k++; end
        chk("hold_granted", 32'(hold_grant), 32'd1);
        chk("hold_bus_idle", 32'(bus_read), 32'd0);
        repeat (6) tick();
        chk("hold_inflight_done", 32'(last_pop_pc), 32'h0041);
        hold_req = 1'b0;
        tick();
        chk("hold_released", 32'(hold_grant), 32'd0);
        n = issue_q.size();
        k = 0;
        while (issue_q.size() <= n && k < 50) begin tick(); k++; end
        chk("hold_resume_addr", 32'(issue_q.size() > n ? issue_q[n] : 16'h0), 32'h0042);

        // Randomized traffic: stalls, back-pressure, holds, redirects, freezes
        rand_wait = 1'b1;
        pops0 = pops;
        for (int c = 0; c < 3000; c++) begin
            active = ($urandom_range(0, 15) != 0);
            out_ready = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 19) == 0) hold_req = ~hold_req;
            if (active && $urandom_range(0, 39) == 0) begin
                flush_addr = 16'($urandom);
                flush = 1'b1;
                exp_q.delete();
                exp_q.push_back(flush_addr);
            end else begin
                flush = 1'b0;
            end
            tick();
        end
        flush = 1'b0; hold_req = 1'b0; active = 1'b1; out_ready = 1'b1;
        repeat (20) tick();
        chk("random_progress", 32'(pops - pops0 >= 50), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
